// File: rtl/multi_channel_frequency_manager_if.sv
// Pixel stream, control pulses and register-write port of the multi-channel frequency manager.
// The master drives the stream and pulses; the slave is the manager itself.
interface multi_channel_frequency_manager_if;
    logic [7:0]  data;
    logic        pixel_valid;
    logic        line_start;
    logic        start;
    logic        stop;
    logic        clear;
    logic        irq;
    logic        busy;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;

    modport master (
        output data, pixel_valid, line_start, start, stop, clear,
        input  irq, busy, register_operation, register_number, register_write
    );

    modport slave (
        input  data, pixel_valid, line_start, start, stop, clear,
        output irq, busy, register_operation, register_number, register_write
    );
endinterface

// File: rtl/multi_channel_frequency_manager.sv
// Watches CHANNELS pixel positions of a video line, measures on/off periods per pixel,
// classifies them as F0/F1/unknown and dumps the counters over a register-write port.
module multi_channel_frequency_manager #(
    parameter int                            CHANNELS      = 4,
    parameter int                            INDEX_WIDTH   = 10,
    parameter logic [CHANNELS*INDEX_WIDTH-1:0] PIXEL_INDICES = {10'd1023, 10'd511, 10'd255, 10'd63},
    parameter logic [7:0]                    THRESHOLD     = 8'hE0,
    parameter logic [CHANNELS*32-1:0]        PERIOD0       = {4{32'd10000}},
    parameter logic [CHANNELS*32-1:0]        PERIOD1       = {4{32'd5000}},
    parameter logic [31:0]                   DEVIATION     = 32'd30,
    parameter int                            COUNTER_WIDTH = 32,
    parameter int                            WRITE_HOLD    = 4
) (
    input logic                               clock,
    input logic                               reset,
    multi_channel_frequency_manager_if.slave  bus
);

    localparam int LAST_REG = 3 * CHANNELS + 1;
    localparam int HOLD_W   = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(WRITE_HOLD - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_r;
    logic [7:0]               slot_r;
    logic [HOLD_W-1:0]        hold_r;
    logic                     irq_r;
    logic                     busy_r;
    logic [1:0]               op_r;
    logic [7:0]               num_r;
    logic [31:0]              wr_r;

    logic [INDEX_WIDTH-1:0]   col_r;
    logic [INDEX_WIDTH-1:0]   eff_col_s;
    logic                     run_s;
    logic                     start_run_s;
    logic [7:0]               next_reg_s;
    logic [31:0]              dump_word_s;

    logic [CHANNELS-1:0]      sample_r;
    logic [CHANNELS-1:0]      sample_d_r;
    logic [CHANNELS-1:0]      armed_r;
    logic [CHANNELS-1:0]      sat_r;
    logic [CHANNELS-1:0]      edge_s;
    logic [CHANNELS-1:0]      measure_s;
    logic [CHANNELS-1:0]      hit0_s;
    logic [CHANNELS-1:0]      hit1_s;
    logic [CHANNELS-1:0]      sat_nxt_s;
    logic [31:0]              period_r  [CHANNELS];
    logic [COUNTER_WIDTH-1:0] f0_r      [CHANNELS];
    logic [COUNTER_WIDTH-1:0] f1_r      [CHANNELS];
    logic [COUNTER_WIDTH-1:0] unk_r     [CHANNELS];
    logic [COUNTER_WIDTH-1:0] f0_nxt_s  [CHANNELS];
    logic [COUNTER_WIDTH-1:0] f1_nxt_s  [CHANNELS];
    logic [COUNTER_WIDTH-1:0] unk_nxt_s [CHANNELS];

    function automatic logic in_window(input logic [31:0] p, input logic [31:0] target);
        logic [31:0] diff;
        diff = (p >= target) ? (p - target) : (target - p);
        return diff <= DEVIATION;
    endfunction

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    assign bus.irq                = irq_r;
    assign bus.busy               = busy_r;
    assign bus.register_operation = op_r;
    assign bus.register_number    = num_r;
    assign bus.register_write     = wr_r;

    // Control qualifiers shared by the datapath and the sequencer
    always_comb begin
        run_s       = (state_r == RUN);
        start_run_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
        eff_col_s   = bus.line_start ? '0 : col_r;
        next_reg_s  = (state_r == DUMP) ? (slot_r + 8'd1) : 8'd1;
    end

    // Column position within the current line
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r <= '0;
        end else if (bus.pixel_valid) begin
            col_r <= bus.line_start ? INDEX_WIDTH'(1) : (col_r + INDEX_WIDTH'(1));
        end else begin
            col_r <= col_r;
        end
    end

    // Classify each armed edge; F0 is tested first so it wins overlapping windows
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            edge_s[c]    = sample_r[c] & ~sample_d_r[c];
            measure_s[c] = run_s & edge_s[c] & armed_r[c];
            hit0_s[c]    = in_window(period_r[c], PERIOD0[c*32 +: 32]);
            hit1_s[c]    = ~hit0_s[c] & in_window(period_r[c], PERIOD1[c*32 +: 32]);
            f0_nxt_s[c]  = (measure_s[c] & hit0_s[c]) ? sat_inc(f0_r[c]) : f0_r[c];
            f1_nxt_s[c]  = (measure_s[c] & hit1_s[c]) ? sat_inc(f1_r[c]) : f1_r[c];
            unk_nxt_s[c] = (measure_s[c] & ~hit0_s[c] & ~hit1_s[c]) ? sat_inc(unk_r[c]) : unk_r[c];
            sat_nxt_s[c] = sat_r[c] | (measure_s[c] & (
                               (hit0_s[c] & (f0_r[c] == CNT_MAX)) |
                               (hit1_s[c] & (f1_r[c] == CNT_MAX)) |
                               (~hit0_s[c] & ~hit1_s[c] & (unk_r[c] == CNT_MAX))));
        end
    end

    // Per-channel sampling, period timing and class counters; frozen outside RUN
    always_ff @(posedge clock) begin
        if (reset || start_run_s) begin
            sample_r   <= '0;
            sample_d_r <= '0;
            armed_r    <= '0;
            sat_r      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                period_r[c] <= 32'd0;
                f0_r[c]     <= '0;
                f1_r[c]     <= '0;
                unk_r[c]    <= '0;
            end
        end else if (run_s) begin
            sample_d_r <= sample_r;
            sat_r      <= sat_nxt_s;
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.pixel_valid && (eff_col_s == PIXEL_INDICES[c*INDEX_WIDTH +: INDEX_WIDTH])) begin
                    sample_r[c] <= (bus.data >= THRESHOLD);
                end
                if (edge_s[c]) begin
                    period_r[c] <= 32'd1;
                    armed_r[c]  <= 1'b1;
                end else if (period_r[c] != 32'hFFFF_FFFF) begin
                    period_r[c] <= period_r[c] + 32'd1;
                end
                f0_r[c]  <= f0_nxt_s[c];
                f1_r[c]  <= f1_nxt_s[c];
                unk_r[c] <= unk_nxt_s[c];
            end
        end
    end

    // Register-map lookup for the slot about to be issued (next-state values so a
    // classification landing on the stop cycle is not lost)
    always_comb begin
        dump_word_s = 32'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (next_reg_s == 8'(3*c + 1)) begin
                dump_word_s = 32'(f0_nxt_s[c]);
            end else if (next_reg_s == 8'(3*c + 2)) begin
                dump_word_s = 32'(f1_nxt_s[c]);
            end else if (next_reg_s == 8'(3*c + 3)) begin
                dump_word_s = 32'(unk_nxt_s[c]);
            end else begin
                dump_word_s = dump_word_s;
            end
        end
        if (next_reg_s == 8'(LAST_REG)) begin
            dump_word_s = 32'(sat_nxt_s);
        end else begin
            dump_word_s = dump_word_s;
        end
    end

    // Control state machine and registered write port
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            slot_r  <= 8'd0;
            hold_r  <= '0;
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
            op_r    <= 2'd0;
            num_r   <= 8'd0;
            wr_r    <= 32'd0;
        end else begin
            op_r  <= 2'd0;
            num_r <= 8'd0;
            wr_r  <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_r <= DUMP;
                        slot_r  <= 8'd1;
                        hold_r  <= '0;
                        op_r    <= 2'd2;
                        num_r   <= next_reg_s;
                        wr_r    <= dump_word_s;
                    end
                end
                DUMP: begin
                    if (hold_r != HOLD_LAST) begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end else if (slot_r == 8'(LAST_REG)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        irq_r   <= 1'b1;
                    end else begin
                        slot_r <= next_reg_s;
                        hold_r <= '0;
                        op_r   <= 2'd2;
                        num_r  <= next_reg_s;
                        wr_r   <= dump_word_s;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_r <= RUN;
                        irq_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (bus.clear) begin
                        state_r <= IDLE;
                        irq_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_frequency_manager.sv
// Directed bench for multi_channel_frequency_manager: expected register writes are queued
// when stop is driven and checked (cycle, number, value) as the DUT issues them.
module tb_multi_channel_frequency_manager;

    localparam int CH  = 3;
    localparam int WH  = 4;
    localparam int NREG = 3 * CH + 1;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_en;

    typedef struct {
        int          cyc;
        int          num;
        logic [31:0] val;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    multi_channel_frequency_manager_if bus();

    multi_channel_frequency_manager #(
        .CHANNELS      (CH),
        .INDEX_WIDTH   (10),
        .PIXEL_INDICES ({10'd63, 10'd1, 10'd0}),
        .THRESHOLD     (8'hE0),
        .PERIOD0       ({32'd130, 32'd200, 32'd100}),
        .PERIOD1       ({32'd65, 32'd150, 32'd50}),
        .DEVIATION     (32'd5),
        .COUNTER_WIDTH (4),
        .WRITE_HOLD    (WH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic px(input logic ls, input logic [7:0] d);
        bus.pixel_valid = 1'b1;
        bus.line_start  = ls;
        bus.data        = d;
        tick();
        bus.pixel_valid = 1'b0;
        bus.line_start  = 1'b0;
        bus.data        = 8'h00;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    // one ch0 rising edge every 100 cycles
    task automatic ch0_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            px(1'b1, 8'hE0);
            idle(49);
            px(1'b1, 8'h00);
            idle(49);
        end
    endtask

    // ch1 sits at column 1: line_start pixel then the column-1 pixel
    task automatic ch1_set(input logic [7:0] v);
        px(1'b1, 8'h00);
        px(1'b0, v);
    endtask

    task automatic line63(input logic [7:0] v);
        px(1'b1, 8'h00);
        for (int col = 1; col <= 64; col++) begin
            if (col == 63)                 px(1'b0, v);
            else if (col == 62 || col == 64) px(1'b0, 8'hE0);
            else                           px(1'b0, 8'h00);
        end
    endtask

    task automatic exp_wr(input int t, input int k, input logic [31:0] v);
        wr_t e;
        e.cyc = t + 1 + (k - 1) * WH;
        e.num = k;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Write-port monitor: every write must match the queue head; idle cycles are all-zero
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.register_operation !== 2'd0) begin
                checks++;
                assert (exp_q.size() > 0 && bus.register_operation === 2'd2) else begin
                    errors++;
                    $error("FAIL unexpected_write op=%0d num=%0d data=%0d at cycle %0d, expected no write",
                           bus.register_operation, bus.register_number, bus.register_write, cyc);
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_number", {24'd0, bus.register_number}, mon_e.num);
                    chk("wr_value", bus.register_write, mon_e.val);
                end
            end else begin
                chk("idle_number", {24'd0, bus.register_number}, 32'd0);
                chk("idle_write", bus.register_write, 32'd0);
            end
        end
    end

    initial begin
        int t;
        int periods[3];
        logic [31:0] run1[NREG];
        logic [31:0] run2[NREG];
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        cyc    = 0;
        reset  = 1'b1;
        bus.data = 8'h00;
        bus.pixel_valid = 1'b0;
        bus.line_start = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.clear = 1'b0;
        periods = '{97, 206, 150};
        run1 = '{32'd10, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        run2 = '{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};

        idle(3);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_op", {30'd0, bus.register_operation}, 32'd0);
        chk("rst_num", {24'd0, bus.register_number}, 32'd0);
        chk("rst_write", bus.register_write, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Run 1: period classification on all three channels
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("run1_busy", {31'd0, bus.busy}, 32'd1);
        chk("run1_irq", {31'd0, bus.irq}, 32'd0);
        ch0_toggle(11);
        idle(20);
        ch1_set(8'hE0);
        for (int i = 0; i < 3; i++) begin
            idle(10);
            ch1_set(8'h00);
            idle(periods[i] - 14);
            ch1_set(8'hE0);
        end
        idle(5);
        for (int i = 0; i < 5; i++) px(1'b0, 8'h00);
        line63(8'hE0);
        line63(8'hDF);
        line63(8'hE0);
        idle(10);
        bus.stop = 1'b1;
        t = cyc;
        for (int k = 1; k <= NREG; k++) exp_wr(t, k, run1[k-1]);
        tick();
        bus.stop = 1'b0;
        chk("dump_busy", {31'd0, bus.busy}, 32'd1);
        wait_until(t + 1 + NREG * WH - 1);
        chk("pre_irq", {31'd0, bus.irq}, 32'd0);
        chk("pre_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("irq_rise", {31'd0, bus.irq}, 32'd1);
        chk("done_busy", {31'd0, bus.busy}, 32'd0);
        chk("run1_all_writes", exp_q.size(), 32'd0);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        idle(3);
        chk("done_stop_ignored", {31'd0, bus.irq}, 32'd1);
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        chk("clear_irq", {31'd0, bus.irq}, 32'd0);
        chk("clear_busy", {31'd0, bus.busy}, 32'd0);
        idle(3);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Run 2: counter saturation and sticky status bit, counters cleared on start
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("run2_busy", {31'd0, bus.busy}, 32'd1);
        ch0_toggle(18);
        idle(20);
        bus.stop = 1'b1;
        t = cyc;
        for (int k = 1; k <= NREG; k++) exp_wr(t, k, run2[k-1]);
        tick();
        bus.stop = 1'b0;
        wait_until(t + 1 + NREG * WH);
        chk("run2_irq", {31'd0, bus.irq}, 32'd1);
        chk("run2_all_writes", exp_q.size(), 32'd0);

        // Run 3: start beats clear in DONE, stop beats start in RUN, reset aborts the dump
        bus.start = 1'b1; bus.clear = 1'b1; tick(); bus.start = 1'b0; bus.clear = 1'b0;
        chk("restart_busy", {31'd0, bus.busy}, 32'd1);
        chk("restart_irq", {31'd0, bus.irq}, 32'd0);
        idle(5);
        bus.start = 1'b1; bus.stop = 1'b1;
        t = cyc;
        for (int k = 1; k <= 3; k++) exp_wr(t, k, 32'd0);
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop_op", {30'd0, bus.register_operation}, 32'd2);
        wait_until(t + 9);
        reset = 1'b1;
        tick();
        chk("abort_op", {30'd0, bus.register_operation}, 32'd0);
        chk("abort_num", {24'd0, bus.register_number}, 32'd0);
        chk("abort_write", bus.register_write, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_irq", {31'd0, bus.irq}, 32'd0);
        reset = 1'b0;
        idle(30);
        chk("abort_stays_idle", {31'd0, bus.busy}, 32'd0);
        chk("abort_no_irq", {31'd0, bus.irq}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
